readout_sequencer: RTL and testbench
====================================

# readout_sequencer

Sequences readback of captured samples from the SRAM interface to the UART transmitter once a capture completes. It issues one memory read strobe per sample and waits for the returned word. It then hands each word to the UART under the UART's busy handshake, and counts down a host-programmed sample count. It sits between the core, the `sram_interface` read port and the `uart` transmit port, and replaces ad-hoc read/send strobing with a single controller that supports abort and timeout.

## Interface
- `MDW`, 32, memory/sample data width.
- `CW`, 16, width of the sample count.
- `TMO`, 255, maximum cycles to wait for read data before declaring a timeout; must be ≥1.

- `clk`  in  1  system clock; every input is synchronous to it.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin readout; ignored unless idle.
- `count`  in  CW  number of samples to send; sampled on an accepted `start`.
- `abort`  in  1  terminates any readout; return to idle.
- `mem_rd`  out  1  single-cycle read strobe to the memory interface.
- `mem_valid`  in  1  read data valid, single cycle.
- `mem_data`  in  MDW  read data, qualified by `mem_valid`.
- `tx_send`  out  1  single-cycle send strobe to the UART.
- `tx_data`  out  MDW  word to transmit; stable from `tx_send` until the next `mem_valid` capture.
- `tx_busy`  in  1  UART busy; a send is legal only when low.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `done`  out  1  single-cycle pulse on completion, including completion by timeout.
- `err`  out  1  sticky timeout flag; cleared by an accepted `start`.

## Operation
- FSM states:
  - IDLE
  - READ
  - WAIT
  - SEND
  - SETTLE
  - FIN
- IDLE:
  - `start`=1 and `abort`=0: load `remaining`=`count` and clear `err`.
  - If `count`=0, go to FIN; otherwise go to READ.
- READ:
  - `mem_rd`=1 for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- WAIT:
  - `mem_valid`=1: register `mem_data` into `tx_data`, go to SEND.
  - Otherwise increment the timeout counter.
  - When the counter reaches `TMO`, set `err`=1 and go to FIN.
- SEND:
  - Hold while `tx_busy`=1.
  - When `tx_busy`=0: `tx_send`=1 for this cycle, decrement `remaining`, go to SETTLE.
- SETTLE:
  - One-cycle guard so the UART can raise `tx_busy`; `tx_busy` is not sampled in this cycle.
  - If `remaining`=0, go to FIN; otherwise go to READ.
- FIN: `done`=1 for this cycle, then go to IDLE.
- `abort`, in any state:
  - Next state is IDLE; `done` is not pulsed.
  - `remaining` and `tx_data` are left unchanged.
  - A word already strobed to the UART completes on its own.
- Priorities:
  - `abort` beats `start` in the same cycle.
  - `abort` beats `mem_valid` in the same cycle; the word is dropped.
- `mem_valid` outside WAIT is ignored.
- `remaining` is CW bits wide and never wraps: decrement happens only in SEND, and only when it is ≥1.
- The timeout counter is `$clog2(TMO+1)` bits wide and saturates at `TMO`.

## Timing
- Reset values:
  - state IDLE
  - `mem_rd`=0, `tx_send`=0, `busy`=0, `done`=0, `err`=0
  - `tx_data`=0, `remaining`=0
- Every output is registered or decoded directly from the state register; no input feeds an output combinationally.
- `start` sampled at edge k:
  - `busy`=1 and `mem_rd`=1 in cycle k+1.
  - Earliest `mem_valid` is cycle k+2.
- Per-sample latency:
  - `mem_valid` in cycle j gives `tx_send` in cycle j+1 when `tx_busy`=0.
  - Minimum per sample is 4 cycles (READ, WAIT, SEND, SETTLE) plus memory latency beyond one cycle.
- After the last `tx_send` in cycle m: FIN in m+2, `done` in m+2, `busy`=0 from m+3.
- `count`=0: `done` in cycle k+1, `busy`=0 in k+2, no `mem_rd`.
- Timeout:
  - `mem_rd` in cycle r with no `mem_valid` gives `err`=1 and FIN in cycle r+TMO+1.
  - `done` pulses in that FIN cycle.
- `rst` mid-operation: all outputs return to reset values immediately (asynchronously).

## Test plan
- **Basic readout.** `count`=3; memory returns data 1 cycle after `mem_rd` (0xA5A50001, 0xA5A50002, 0xA5A50003); `tx_busy`=0.
  - Expect 3 `mem_rd` and 3 `tx_send`, with `tx_data` in order.
  - Expect one `done` 2 cycles after the 3rd `tx_send`, and `err`=0.
- **Backpressure.** As above, but `tx_busy` held high for 10 cycles after each send.
  - Each `tx_send` occurs exactly 1 cycle after `tx_busy` falls; never 2 sends while busy.
- **Zero count.** `count`=0 → `done` 1 cycle after `start`, no `mem_rd`, `busy` high for 1 cycle.
- **Timeout.** `TMO`=8, `mem_valid` never asserted.
  - `err`=1 and `done` 9 cycles after `mem_rd`, then IDLE.
  - A new `start` clears `err`.
- **Abort.** Abort during WAIT of sample 2 of 5, asserted together with `mem_valid`.
  - No further `tx_send`, no `done`, `busy`=0 next cycle.
  - `start`+`abort` in the same cycle leaves the FSM in IDLE.
- **Async reset.** Assert `rst` mid-SEND → all outputs reach reset values before the next edge; a `start` after release behaves normally.

Source files
------------

// File: rtl/readout_sequencer_if.sv
// Bundle of the core, memory read-port and UART transmit-port signals seen by readout_sequencer.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface readout_sequencer_if #(
  parameter int unsigned MDW = 32,
  parameter int unsigned CW  = 16
);
  logic           start;
  logic [CW-1:0]  count;
  logic           abort;
  logic           mem_rd;
  logic           mem_valid;
  logic [MDW-1:0] mem_data;
  logic           tx_send;
  logic [MDW-1:0] tx_data;
  logic           tx_busy;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    output start, count, abort, mem_valid, mem_data, tx_busy,
    input  mem_rd, tx_send, tx_data, busy, done, err
  );

  modport slave (
    input  start, count, abort, mem_valid, mem_data, tx_busy,
    output mem_rd, tx_send, tx_data, busy, done, err
  );
endinterface

// File: rtl/readout_sequencer.sv
// Reads a programmed number of samples from memory and hands each one to the UART,
// with abort, read timeout and a sticky timeout error flag.
module readout_sequencer #(
  parameter int unsigned MDW = 32,
  parameter int unsigned CW  = 16,
  parameter int unsigned TMO = 255
) (
  input logic                clk,
  input logic                rst,
  readout_sequencer_if.slave bus_io
);
  localparam int unsigned   TW     = $clog2(TMO + 1);
  localparam logic [TW-1:0] TmoMax = TW'(TMO);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StSend,
    StSettle,
    StFin
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  remaining_q;
  logic [TW-1:0]  tmo_cnt_q;
  logic [TW-1:0]  tmo_cnt_inc;
  logic [MDW-1:0] tx_data_q;
  logic           mem_rd_q;
  logic           tx_send_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;

  assign tmo_cnt_inc = (tmo_cnt_q == TmoMax) ? tmo_cnt_q : tmo_cnt_q + TW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      tmo_cnt_q   <= '0;
      tx_data_q   <= '0;
      mem_rd_q    <= 1'b0;
      tx_send_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_rd_q  <= 1'b0;
      tx_send_q <= 1'b0;
      done_q    <= 1'b0;
      if (bus_io.abort) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus_io.start) begin
              remaining_q <= bus_io.count;
              err_q       <= 1'b0;
              busy_q      <= 1'b1;
              if (bus_io.count == '0) begin
                state_q <= StFin;
                done_q  <= 1'b1;
              end else begin
                state_q  <= StRead;
                mem_rd_q <= 1'b1;
              end
            end
          end
          StRead: begin
            tmo_cnt_q <= '0;
            state_q   <= StWait;
          end
          StWait: begin
            if (bus_io.mem_valid) begin
              tx_data_q <= bus_io.mem_data;
              state_q   <= StSend;
              // Strobe in the first SEND cycle if the UART is already free.
              tx_send_q <= ~bus_io.tx_busy;
            end else begin
              tmo_cnt_q <= tmo_cnt_inc;
              if (tmo_cnt_inc == TmoMax) begin
                err_q   <= 1'b1;
                done_q  <= 1'b1;
                state_q <= StFin;
              end
            end
          end
          StSend: begin
            // A SEND cycle with tx_send_q high is the strobe cycle; otherwise keep polling.
            if (tx_send_q) begin
              if (remaining_q != '0) begin
                remaining_q <= remaining_q - CW'(1);
              end
              state_q <= StSettle;
            end else begin
              tx_send_q <= ~bus_io.tx_busy;
            end
          end
          StSettle: begin
            if (remaining_q == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q  <= StRead;
              mem_rd_q <= 1'b1;
            end
          end
          StFin: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus_io.mem_rd  = mem_rd_q;
  assign bus_io.tx_send = tx_send_q;
  assign bus_io.tx_data = tx_data_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.done    = done_q;
  assign bus_io.err     = err_q;
endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: readout, backpressure, zero count, timeout, abort, reset.
module tb_readout_sequencer;
  localparam int unsigned MDW = 32;
  localparam int unsigned CW  = 16;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resp_en = 1'b1;
  logic bp_en = 1'b0;

  readout_sequencer_if #(.MDW(MDW), .CW(CW)) bus ();

  readout_sequencer #(
    .MDW(MDW),
    .CW (CW),
    .TMO(TMO)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle counter and event monitor
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int rd_n = 0, send_n = 0, done_n = 0, sbw_n = 0, rd_cyc = 0, done_cyc = 0;
  int send_cyc[64];
  logic [MDW-1:0] send_data[64];
  initial forever begin
    @(negedge clk);
    if (bus.mem_rd) begin
      rd_n++;
      rd_cyc = cyc;
    end
    if (bus.tx_send) begin
      if (bus.tx_busy) sbw_n++;
      if (send_n < 64) begin
        send_cyc[send_n]  = cyc;
        send_data[send_n] = bus.tx_data;
      end
      send_n++;
    end
    if (bus.done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  // Memory model: data one cycle after each read strobe
  int resp_n = 0;
  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(negedge clk);
      if (resp_en && bus.mem_rd) begin
        @(posedge clk);
        #1;
        resp_n++;
        bus.mem_valid = 1'b1;
        bus.mem_data  = MDW'(32'hA5A5_0000 + resp_n);
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
      end
    end
  end

  // UART model: busy for 10 cycles after each send when backpressure is enabled
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bp_en && bus.tx_send) begin
        @(posedge clk);
        #1;
        bus.tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic pulse_start(input logic [CW-1:0] n);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.count = n;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    for (int i = 0; i < budget && done_n == base; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq(tag, 64'(done_n - base), 64'd1);
  endtask

  int b_rd, b_send, b_done, b_sbw, b_resp;

  task automatic snap();
    b_rd   = rd_n;
    b_send = send_n;
    b_done = done_n;
    b_sbw  = sbw_n;
    b_resp = resp_n;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.count = '0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_flags", 64'({bus.mem_rd, bus.tx_send, bus.busy, bus.done, bus.err}), 64'd0);
    check_eq("reset_tx_data", 64'(bus.tx_data), 64'd0);
    rst = 1'b0;

    // Basic readout of 3 samples
    snap();
    pulse_start(16'd3);
    @(negedge clk);
    check_eq("basic_busy_k1", 64'(bus.busy), 64'd1);
    check_eq("basic_rd_k1", 64'(bus.mem_rd), 64'd1);
    wait_done("basic_done", b_done, 100);
    check_eq("basic_rd_n", 64'(rd_n - b_rd), 64'd3);
    check_eq("basic_send_n", 64'(send_n - b_send), 64'd3);
    check_eq("basic_d0", 64'(send_data[b_send]), 64'hA5A5_0001);
    check_eq("basic_d1", 64'(send_data[b_send+1]), 64'hA5A5_0002);
    check_eq("basic_d2", 64'(send_data[b_send+2]), 64'hA5A5_0003);
    check_eq("basic_gap01", 64'(send_cyc[b_send+1] - send_cyc[b_send]), 64'd4);
    check_eq("basic_done_lat", 64'(done_cyc - send_cyc[b_send+2]), 64'd2);
    check_eq("basic_err", 64'(bus.err), 64'd0);
    @(negedge clk);
    check_eq("basic_idle", 64'(bus.busy), 64'd0);

    // Backpressure: UART busy 10 cycles after every send
    bp_en = 1'b1;
    snap();
    pulse_start(16'd3);
    wait_done("bp_done", b_done, 300);
    check_eq("bp_send_n", 64'(send_n - b_send), 64'd3);
    check_eq("bp_gap01", 64'(send_cyc[b_send+1] - send_cyc[b_send]), 64'd12);
    check_eq("bp_gap12", 64'(send_cyc[b_send+2] - send_cyc[b_send+1]), 64'd12);
    check_eq("bp_sbw", 64'(sbw_n - b_sbw), 64'd0);
    check_eq("bp_d2", 64'(send_data[b_send+2]), 64'(32'hA5A5_0000 + b_resp + 3));
    bp_en = 1'b0;
    repeat (12) @(posedge clk);

    // Zero count
    snap();
    pulse_start(16'd0);
    @(negedge clk);
    check_eq("zero_done", 64'(bus.done), 64'd1);
    check_eq("zero_busy", 64'(bus.busy), 64'd1);
    check_eq("zero_rd", 64'(bus.mem_rd), 64'd0);
    @(negedge clk);
    check_eq("zero_idle", 64'({bus.busy, bus.done}), 64'd0);
    check_eq("zero_rd_n", 64'(rd_n - b_rd), 64'd0);

    // Timeout with no memory response
    resp_en = 1'b0;
    snap();
    pulse_start(16'd2);
    wait_done("tmo_done", b_done, 60);
    check_eq("tmo_lat", 64'(done_cyc - rd_cyc), 64'(TMO + 1));
    check_eq("tmo_err", 64'(bus.err), 64'd1);
    check_eq("tmo_rd_n", 64'(rd_n - b_rd), 64'd1);
    check_eq("tmo_send_n", 64'(send_n - b_send), 64'd0);
    @(negedge clk);
    check_eq("tmo_idle", 64'(bus.busy), 64'd0);
    check_eq("tmo_err_sticky", 64'(bus.err), 64'd1);
    resp_en = 1'b1;
    snap();
    pulse_start(16'd1);
    @(negedge clk);
    check_eq("tmo_err_clr", 64'(bus.err), 64'd0);
    wait_done("tmo_rec_done", b_done, 60);
    check_eq("tmo_rec_data", 64'(send_data[b_send]), 64'(32'hA5A5_0000 + b_resp + 1));

    // Abort in WAIT of sample 2 of 5, together with mem_valid
    @(negedge clk);
    snap();
    pulse_start(16'd5);
    for (int i = 0; i < 100 && rd_n < b_rd + 2; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("abort_rd2", 64'(rd_n - b_rd), 64'd2);
    @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 64'(bus.busy), 64'd0);
    repeat (20) @(negedge clk);
    check_eq("abort_send_n", 64'(send_n - b_send), 64'd1);
    check_eq("abort_done_n", 64'(done_n - b_done), 64'd0);
    check_eq("abort_rd_n", 64'(rd_n - b_rd), 64'd2);
    check_eq("abort_tx_data", 64'(bus.tx_data), 64'(32'hA5A5_0000 + b_resp + 1));

    // start and abort together
    snap();
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.count = 16'd2;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check_eq("sa_busy", 64'({bus.busy, bus.mem_rd}), 64'd0);
    repeat (5) @(negedge clk);
    check_eq("sa_rd_n", 64'(rd_n - b_rd), 64'd0);

    // Asynchronous reset while holding in SEND
    bp_en = 1'b1;
    snap();
    pulse_start(16'd3);
    for (int i = 0; i < 100 && send_n < b_send + 1; i++) begin
      @(negedge clk);
      #1;
    end
    check_eq("rst_first_send", 64'(send_n - b_send), 64'd1);
    repeat (5) @(posedge clk);
    check_eq("rst_pre_data", 64'(bus.tx_data), 64'(32'hA5A5_0000 + b_resp + 2));
    #3;
    rst = 1'b1;
    #1;
    check_eq("rst_flags", 64'({bus.mem_rd, bus.tx_send, bus.busy, bus.done, bus.err}), 64'd0);
    check_eq("rst_tx_data", 64'(bus.tx_data), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    bp_en = 1'b0;
    repeat (15) @(posedge clk);
    snap();
    pulse_start(16'd1);
    @(negedge clk);
    check_eq("post_rst_rd", 64'({bus.busy, bus.mem_rd}), 64'd3);
    wait_done("post_rst_done", b_done, 60);
    check_eq("post_rst_data", 64'(send_data[b_send]), 64'(32'hA5A5_0000 + b_resp + 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
